region_data_memory: RTL and testbench
=====================================

# region_data_memory

Parametrised, handshaked data-memory block for the single-cycle/multi-cycle MIPS datapath. It decodes up to four address regions by upper-16-bit tag, each backed by its own word-organised RAM. It performs byte/half/word loads and stores with byte-lane steering and sign/zero extension, and returns each result through a valid/ready response channel after a configurable latency. It sits between the load/store unit and the memory-mapped address space, replacing fixed-size, word-only, unregistered region memories.

## Interface
- N_REGIONS, 2: number of populated regions, 1..4.
- REGION0_TAG, 16'h1000: addr[31:16] match value for region 0 (static data/RAM).
- REGION1_TAG, 16'h7fff: region 1 tag (stack).
- REGION2_TAG, 16'h2000: region 2 tag; ignored if N_REGIONS < 3.
- REGION3_TAG, 16'h3000: region 3 tag; ignored if N_REGIONS < 4.
- DEPTH_WORDS, 1024: 32-bit words per region; power of two, 16..16384.
- LATENCY, 1: cycles from request accept to rsp_valid, 1..4.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified: byte in [7:0], half in [15:0].
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10/11 word.
- req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  2  00 ok, 01 unmapped, 10 misaligned.

## Operation
- FSM states are IDLE, WAIT and RESP. `req_ready` = (state == IDLE) and reset deasserted.
- **Accept:** a request is accepted on a rising edge with req_valid && req_ready. All request fields are captured in that edge.
- **Decode:** `hit[i]` = (addr[31:16] == REGIONi_TAG), for i < N_REGIONS.
  - If tags are duplicated, the lowest i wins.
  - No hit gives err 01. No RAM is accessed.
- **Alignment:** a half with addr[0]=1, or a word with addr[1:0]≠0, gives err 10.
  - Unmapped takes priority over misaligned.
  - An erroring request performs no write.
- **Word index:** addr[log2(DEPTH_WORDS)+1:2]. Upper address bits between the index and the tag are ignored, so the region aliases/wraps.
- **Store:** written on the accept edge with byte enables.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all lanes.
  - Other lanes of the word are unchanged.
- **Load:** the word is read from the addressed region.
  - The lane is selected by addr[1:0] for a byte, or by addr[1] for a half.
  - The result is right-justified, then extended from bit 7 or bit 15 per req_sign. Words pass unchanged.
- **Transitions:**
  - After accept, the FSM goes to RESP if LATENCY=1, else to WAIT with the counter loaded to LATENCY-2.
  - WAIT decrements the counter each cycle and moves to RESP when the counter reaches 0.
  - RESP holds rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1.
  - A RESP handshake returns the FSM to IDLE.
- **Single outstanding request:** no new request is accepted in the response handshake cycle.

## Timing
- **Reset values (reset=0, asynchronous):** state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0, req_ready 0. RAM contents are not reset.
- req_ready rises in the first cycle after reset deasserts.
- **Response timing:** for a request accepted at edge E, rsp_valid is 1 in the cycle following edge E+LATENCY-1. The first valid cycle is therefore LATENCY cycles after acceptance. This applies to loads, stores and errors alike.
- **Throughput:** with rsp_ready tied to 1, throughput is one request per LATENCY+1 cycles.
- **Read-after-write:** a load accepted after a store's response handshake returns the stored data. No bypass is needed because only one request is outstanding.
- **Backpressure:** rsp_ready=0 stalls indefinitely in RESP. Outputs must not change while stalled.
- **Reset mid-operation:** the FSM returns to IDLE and no response is issued. A store already written on its accept edge stays committed.
- Request-side inputs are don't-care when req_ready=0.

## Test plan
- **Word store/load, region 0, LATENCY=1:** store 0xDEADBEEF at 0x10000010, then load the word from 0x10000010.
  - Store response: err 00, rdata 0.
  - Load: rsp_valid rises 1 cycle after accept with rdata 0xDEADBEEF.
- **Sub-word:** with word 0x10000010 = 0xDEADBEEF:
  - Byte load, sign=1, at 0x10000011 returns 0xFFFFFFBE.
  - Byte load, sign=0, at the same address returns 0x000000BE.
  - Half load, sign=1, at 0x10000012 returns 0xFFFFDEAD.
  - A byte store of 0x55 to 0x10000013 makes the word read back as 0x55ADBEEF.
- **Errors:**
  - A load at 0x20000000 (N_REGIONS=2) returns err 01.
  - A half store at 0x7FFF0001 returns err 10, and a subsequent word read at 0x7FFF0000 is unchanged.
  - A word load at 0x40000003 returns err 01, because unmapped has priority.
- **Latency/backpressure, LATENCY=3:**
  - rsp_valid first rises 3 cycles after accept.
  - Holding rsp_ready=0 for 5 cycles keeps rsp_valid, rdata and err constant and req_ready=0.
  - req_ready=1 in the cycle after the handshake.
- **Wrap/alias, DEPTH_WORDS=16:** a word store of 0x12345678 at 0x10000000, then a load at 0x10000040, returns 0x12345678.
- **Reset mid-operation, LATENCY=4:** assert reset 2 cycles after accepting a store.
  - rsp_valid=0 immediately and never pulses for that request.
  - After release, a load at the same address returns the stored data.

Source files
------------

// File: rtl/region_data_memory_if.sv
// Load/store request and response channel between the LSU (master) and region_data_memory (slave).
// Requests and responses each use a valid/ready handshake.
interface region_data_memory_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_size, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_size, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/region_data_memory.sv
// Tag-decoded multi-region data RAM with byte/half/word access; response LATENCY cycles after accept.
// One request outstanding; rsp_ready low holds the response (and blocks new requests) indefinitely.
module region_data_memory #(
  parameter int          N_REGIONS   = 2,
  parameter logic [15:0] REGION0_TAG = 16'h1000,
  parameter logic [15:0] REGION1_TAG = 16'h7fff,
  parameter logic [15:0] REGION2_TAG = 16'h2000,
  parameter logic [15:0] REGION3_TAG = 16'h3000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  region_data_memory_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int RW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;
  localparam logic [15:0] TAGS [4] = '{REGION0_TAG, REGION1_TAG, REGION2_TAG, REGION3_TAG};

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q;
  logic [1:0]      err_q;
  logic            load_ok_q;
  logic [1:0]      lane_q;
  logic [1:0]      size_q;
  logic            sign_q;
  logic [31:0]     rd_q;

  logic            req_rdy;
  logic            accept;
  logic            hit_any;
  logic [RW-1:0]   hit_idx;
  logic            misalign;
  logic [1:0]      req_err;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [AW-1:0]   idx;
  logic            wr_go;

  logic [31:0]     mem [N_REGIONS][DEPTH_WORDS];

  // Lowest-numbered matching region wins when tags are duplicated.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (!hit_any && bus.req_addr[31:16] == TAGS[i]) begin
        hit_any = 1'b1;
        hit_idx = RW'(i);
      end
    end
  end

  assign misalign = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                    (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign req_err  = !hit_any ? 2'b01 : (misalign ? 2'b10 : 2'b00);
  assign idx      = bus.req_addr[AW+1:2];
  assign accept   = bus.req_valid && req_rdy;
  assign wr_go    = accept && bus.req_we && (req_err == 2'b00);

  always_comb begin
    case (bus.req_size)
      2'b00: begin
        be     = 4'b0001 << bus.req_addr[1:0];
        wlanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = bus.req_wdata;
      end
    endcase
  end

  generate
    if (AW < 14) begin : g_alias_bits
      // Bits between the word index and the tag are ignored, so each region wraps.
      logic unused_alias_bits;
      assign unused_alias_bits = ^bus.req_addr[15:AW+2];
    end
  endgenerate

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[hit_idx][idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
    if (accept) rd_q <= mem[hit_idx][idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rdy       = (state_q == IDLE) && rst_n;
    bus.req_ready = req_rdy;
    bus.rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      err_q     <= 2'b00;
      load_ok_q <= 1'b0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      sign_q    <= 1'b0;
    end else if (accept) begin
      cnt_q     <= CNT_INIT;
      err_q     <= req_err;
      load_ok_q <= !bus.req_we && (req_err == 2'b00);
      lane_q    <= bus.req_addr[1:0];
      size_q    <= bus.req_size;
      sign_q    <= bus.req_sign;
    end else if (state_q == WAIT && cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // Lane select and extension work off captured fields, so the response is stable while stalled.
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  always_comb begin
    sel_b         = rd_q[{lane_q, 3'b000} +: 8];
    sel_h         = lane_q[1] ? rd_q[31:16] : rd_q[15:0];
    bus.rsp_rdata = '0;
    bus.rsp_err   = err_q;
    if (load_ok_q) begin
      case (size_q)
        2'b00:   bus.rsp_rdata = sign_q ? {{24{sel_b[7]}}, sel_b} : {24'b0, sel_b};
        2'b01:   bus.rsp_rdata = sign_q ? {{16{sel_h[15]}}, sel_h} : {16'b0, sel_h};
        default: bus.rsp_rdata = rd_q;
      endcase
    end
  end

endmodule

// File: tb/tb_region_data_memory.sv
// Directed + randomized bench for region_data_memory against a byte-addressed reference memory.
module tb_region_data_memory;
  localparam int LAT    = 3;
  localparam int DEPTH  = 16;
  localparam int RBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  region_data_memory_if bus ();

  region_data_memory #(
    .N_REGIONS(2), .REGION0_TAG(16'h1000), .REGION1_TAG(16'h7fff),
    .REGION2_TAG(16'h2000), .REGION3_TAG(16'h3000),
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mem_m [2*RBYTES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory per region, offset = address modulo region size.
  task automatic model(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er);
    int r, base, n;
    logic [31:0] v;
    rd = '0;
    r  = -1;
    if (a[31:16] == 16'h1000) r = 0;
    else if (a[31:16] == 16'h7fff) r = 1;
    n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    if (r < 0) er = 2'b01;
    else if (int'(a[1:0]) % n != 0) er = 2'b10;
    else begin
      er   = 2'b00;
      base = r * RBYTES + int'(a % 32'(RBYTES));
      if (we) begin
        for (int k = 0; k < n; k++) mem_m[base+k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mem_m[base+k]) << (8*k));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  task automatic do_txn(input string tag, input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic [1:0] er);
    logic [31:0] exp_rd;
    logic [1:0]  exp_er;
    int n;
    model(a, we, sz, sg, wd, exp_rd, exp_er);
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_sign  = sg;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_we    = 1'($urandom);
    bus.req_size  = 2'($urandom);
    bus.req_sign  = 1'($urandom);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(LAT));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    chk({tag, "/rdata"}, rd, exp_rd);
    chk({tag, "/err"}, 32'(er), 32'(exp_er));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "/stall_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "/stall_rdata"}, bus.rsp_rdata, exp_rd);
      chk({tag, "/stall_err"}, 32'(bus.rsp_err), 32'(exp_er));
      chk({tag, "/stall_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "/post_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "/post_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, a;
    logic [1:0]  er, exp_er;
    logic [15:0] tag_hi;
    int n;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sign  = 1'b0;
    #1;
    chk("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset/req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset/rsp_err", 32'(bus.rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset_release/req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Give every word of both regions a known value.
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < DEPTH; w++) begin
        a = {(r == 0) ? 16'h1000 : 16'h7fff, 16'(w * 4)};
        do_txn("prefill", a, 1'b1, 2'b10, 1'b0, $urandom, 0, rd, er);
      end
    end

    do_txn("st_word", 32'h1000_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, rd, er);
    chk("st_word/const_rdata", rd, 32'd0);
    chk("st_word/const_err", 32'(er), 32'd0);
    do_txn("ld_word", 32'h1000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("ld_word/const", rd, 32'hDEAD_BEEF);
    do_txn("ld_byte_s", 32'h1000_0011, 1'b0, 2'b00, 1'b1, 32'h0, 0, rd, er);
    chk("ld_byte_s/const", rd, 32'hFFFF_FFBE);
    do_txn("ld_byte_u", 32'h1000_0011, 1'b0, 2'b00, 1'b0, 32'h0, 0, rd, er);
    chk("ld_byte_u/const", rd, 32'h0000_00BE);
    do_txn("ld_half_s", 32'h1000_0012, 1'b0, 2'b01, 1'b1, 32'h0, 0, rd, er);
    chk("ld_half_s/const", rd, 32'hFFFF_DEAD);
    do_txn("st_byte", 32'h1000_0013, 1'b1, 2'b00, 1'b0, 32'hAABB_CC55, 0, rd, er);
    do_txn("ld_after_byte", 32'h1000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("ld_after_byte/const", rd, 32'h55AD_BEEF);

    do_txn("unmapped", 32'h2000_0000, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("unmapped/const", 32'(er), 32'd1);
    do_txn("misalign_st", 32'h7FFF_0001, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 0, rd, er);
    chk("misalign_st/const", 32'(er), 32'd2);
    do_txn("misalign_chk", 32'h7FFF_0000, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    do_txn("unmapped_prio", 32'h4000_0003, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("unmapped_prio/const", 32'(er), 32'd1);

    do_txn("backpressure", 32'h1000_0010, 1'b0, 2'b00, 1'b1, 32'h0, 5, rd, er);

    do_txn("wrap_st", 32'h1000_0000, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 0, rd, er);
    do_txn("wrap_ld", 32'h1000_0040, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("wrap_ld/const", rd, 32'h1234_5678);

    // Reset one cycle into a store's latency; the write is already committed.
    model(32'h1000_0020, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, exp_rd, exp_er);
    bus.req_addr  = 32'h1000_0020;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_sign  = 1'b0;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_valid = 1'b1;
    chk("rst_mid/req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid/req_ready_low", 32'(bus.req_ready), 32'd0);
    chk("rst_mid/rsp_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) n++;
    end
    chk("rst_mid/no_pulse", 32'(n), 32'd0);
    do_txn("rst_mid_ld", 32'h1000_0020, 1'b0, 2'b10, 1'b0, 32'h0, 0, rd, er);
    chk("rst_mid_ld/const", rd, 32'hCAFE_F00D);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: tag_hi = 16'h1000;
        3, 4:    tag_hi = 16'h7fff;
        default: tag_hi = 16'h2000 + 16'($urandom_range(0, 255));
      endcase
      a = {tag_hi, 16'($urandom)};
      do_txn("rand", a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
             $urandom_range(0, 2), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
